// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the PISO shifter
//
// Purpose: state encoding, default frame width and counter-width helper
//          used by piso_shifter.
// Ports:   none (package).
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH so a full frame never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parametrised parallel-in serial-out shifter
//
// Purpose: accepts a WIDTH-bit word over a valid/ready handshake and streams
//          it on so one bit per clock, LSB-first or MSB-first per word, with
//          gap-free back-to-back frames.
// Optional: PISO_PARITY_EN appends one even-parity bit after each frame.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_valid in   load_data/msb_first valid
//   load_ready out  word can be accepted this cycle
//   load_data  in   WIDTH-bit word to serialise
//   msb_first  in   1 = bit WIDTH-1 first, 0 = bit 0 first
//   so         out  registered serial data
//   so_valid   out  so carries a frame bit
//   busy       out  frame in progress
//   done       out  high while the last bit of a frame is on so
import piso_pkg::*;

module piso_shifter #(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CW-1:0] PENULT_CNT = CW'(WIDTH - 2);
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_msb, w_msb_nxt;
  logic             r_so, w_so_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_last;
`ifdef PISO_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_last = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);

  // The back-to-back window is the final bit of a frame; with parity that
  // final bit is the parity cycle, not the last data bit.
`ifdef PISO_PARITY_EN
  assign load_ready = (r_state == ST_IDLE) || (r_state == ST_PARITY);
`else
  assign load_ready = (r_state == ST_IDLE) || w_last;
`endif

  assign w_accept = load_valid && load_ready;

  // Shift toward the output end; vacated bit is zero-filled.
  assign w_shifted = r_msb ? {r_shift[WIDTH-2:0], 1'b0}
                           : {1'b0, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_msb_nxt   = r_msb;
    w_so_nxt    = r_so;
    w_done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_shift_nxt = load_data;
      w_msb_nxt   = msb_first;
      w_cnt_nxt   = '0;
      w_so_nxt    = msb_first ? load_data[WIDTH-1] : load_data[0];
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^load_data;
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_last) begin
`ifdef PISO_PARITY_EN
            w_state_nxt = ST_PARITY;
            w_so_nxt    = r_par;
            w_done_nxt  = 1'b1;
`else
            w_state_nxt = ST_IDLE;
            w_so_nxt    = IDLE_LEVEL;
            w_cnt_nxt   = '0;
`endif
          end else begin
            w_shift_nxt = w_shifted;
            w_so_nxt    = r_msb ? w_shifted[WIDTH-1] : w_shifted[0];
            w_cnt_nxt   = r_cnt + 1'b1;
`ifndef PISO_PARITY_EN
            // done is registered: raise it as the last bit goes onto so.
            w_done_nxt  = (r_cnt == PENULT_CNT);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        ST_PARITY: begin
          w_state_nxt = ST_IDLE;
          w_so_nxt    = IDLE_LEVEL;
          w_cnt_nxt   = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_msb   <= 1'b0;
      r_so    <= IDLE_LEVEL;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_msb   <= w_msb_nxt;
      r_so    <= w_so_nxt;
      r_done  <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign so       = r_so;
  assign so_valid = (r_state != ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_piso_shifter.sv
// tb/tb_piso_shifter.sv - self-checking bench for piso_shifter
module tb_piso_shifter;

  localparam int   WIDTH      = 8;
  localparam logic IDLE_LEVEL = 1'b0;
`ifdef PISO_PARITY_EN
  localparam int   FLEN = WIDTH + 1;
`else
  localparam int   FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  piso_shifter #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .so         (so),
    .so_valid   (so_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: the bits still to appear on so, in order.
  bit          model_q[$];
  logic [31:0] col;
  int          ncol;
  int          ndone;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_col();
    col   = '0;
    ncol  = 0;
    ndone = 0;
  endtask

  task automatic step(input logic lv, input logic [WIDTH-1:0] d, input logic m);
    logic m_ready;
    logic acc;
    @(negedge clk);
    m_ready = (model_q.size() <= 1);
    check("so",         so,         (model_q.size() != 0) ? model_q[0] : IDLE_LEVEL);
    check("so_valid",   so_valid,   model_q.size() != 0);
    check("busy",       busy,       model_q.size() != 0);
    check("done",       done,       model_q.size() == 1);
    check("load_ready", load_ready, m_ready);
    if (so_valid) begin
      col = {col[30:0], so};
      ncol++;
    end
    if (done) ndone++;
    load_valid = lv;
    load_data  = d;
    msb_first  = m;
    acc = lv && m_ready;
    @(posedge clk);
    if (model_q.size() != 0) void'(model_q.pop_front());
    if (acc) begin
      for (int i = 0; i < WIDTH; i++)
        model_q.push_back(m ? d[WIDTH-1-i] : d[i]);
`ifdef PISO_PARITY_EN
      model_q.push_back(^d);
`endif
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), 1'($urandom));
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    msb_first  = 1'b0;
    #2;
    check("rst_so",       so,       IDLE_LEVEL);
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 0x96 LSB-first
    clear_col();
    step(1'b1, 8'h96, 1'b0);
    idle_steps(FLEN + 2);
`ifdef PISO_PARITY_EN
    check("lsb96_bits", col, 32'h0D2);
`else
    check("lsb96_bits", col, 32'h69);
`endif
    check("lsb96_len",  ncol,  FLEN);
    check("lsb96_done", ndone, 1);

    // 0x96 MSB-first
    clear_col();
    step(1'b1, 8'h96, 1'b1);
    idle_steps(FLEN + 2);
`ifdef PISO_PARITY_EN
    check("msb96_bits", col, 32'h12C);
`else
    check("msb96_bits", col, 32'h96);
`endif
    check("msb96_len", ncol, FLEN);

    // 0x97 LSB-first (odd number of ones)
    clear_col();
    step(1'b1, 8'h97, 1'b0);
    idle_steps(FLEN + 2);
`ifdef PISO_PARITY_EN
    check("lsb97_bits", col, 32'h1D3);
`else
    check("lsb97_bits", col, 32'hE9);
`endif

    // back-to-back: 0x96 LSB then 0x3C MSB held until accepted
    clear_col();
    step(1'b1, 8'h96, 1'b0);
    for (int i = 0; i < FLEN; i++) step(1'b1, 8'h3C, 1'b1);
    idle_steps(FLEN + 2);
`ifdef PISO_PARITY_EN
    check("b2b_bits", col, 32'h1A478);
`else
    check("b2b_bits", col, 32'h693C);
`endif
    check("b2b_len",  ncol,  2 * FLEN);
    check("b2b_done", ndone, 2);

    // load_valid pulsed with 0xFF during bits 2..5 is ignored
    clear_col();
    step(1'b1, 8'h96, 1'b0);
    idle_steps(2);
    for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b1);
    idle_steps(FLEN - 4);
`ifdef PISO_PARITY_EN
    check("ign_bits", col, 32'h0D2);
`else
    check("ign_bits", col, 32'h69);
`endif
    check("ign_len", ncol, FLEN);

    // asynchronous reset at bit 3
    step(1'b1, 8'h96, 1'b0);
    idle_steps(3);
    @(negedge clk);
    check("pre_rst_valid", so_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_so_valid", so_valid, 1'b0);
    check("arst_busy",     busy,     1'b0);
    check("arst_done",     done,     1'b0);
    check("arst_so",       so,       IDLE_LEVEL);
    model_q.delete();
    @(negedge clk);
    check("arst_done_hold", done, 1'b0);
    rst = 1'b0;
    clear_col();
    step(1'b1, 8'h01, 1'b0);
    idle_steps(FLEN + 2);
`ifdef PISO_PARITY_EN
    check("post_rst_bits", col, 32'h101);
`else
    check("post_rst_bits", col, 32'h80);
`endif
    check("post_rst_done", ndone, 1);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, WIDTH'($urandom), 1'($urandom));
    idle_steps(FLEN + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parametrised parallel-in serial-out shifter; the successor to the fixed 4-bit PISO.
- Accepts a WIDTH-bit word over a valid/ready load handshake and streams it out one bit per clock, LSB-first or MSB-first per word.
- Supports gap-free back-to-back frames.
- Sits between a parallel data source (register file or FIFO) and a serial link or test pin driver.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..64.
- IDLE_LEVEL, 1'b0, value driven on so when no frame is active.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data and msb_first are valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialise.
- msb_first  input  1  sampled at accept: 1 = bit WIDTH-1 first, 0 = bit 0 first.
- so  output  1  serial data out (registered).
- so_valid  output  1  so carries a frame bit this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse, high while the last bit of a frame is on so.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, shift register=0, bit counter=0, direction flag=0.
  - so=IDLE_LEVEL, so_valid=0, busy=0, done=0.
  - load_ready=1 once rst deasserts.
- States: IDLE, SHIFT (plus PARITY with the optional feature).
- Accept condition: load_valid && load_ready at a rising edge.
- load_ready is combinational: high in IDLE, and high in SHIFT only on the last-bit cycle (counter==WIDTH-1). Low otherwise.
- On accept:
  - Latch load_data and msb_first.
  - Drive the first bit on so at that same edge.
  - Set so_valid=1, busy=1, counter=0, state=SHIFT.
  - First bit is visible the cycle after the accept edge (latency 1).
- In SHIFT, each edge:
  - Shift the register toward the output end: right-shift when LSB-first, left-shift when MSB-first.
  - Zero-fill the vacated bit.
  - Present the next bit and increment the counter.
- so_valid is high for exactly WIDTH consecutive cycles per frame.
- done=1 on the cycle so carries bit WIDTH entries into the frame (counter==WIDTH-1, registered).
- End of frame, at the edge after the last bit:
  - With an accept at that edge: reload immediately. so_valid stays high and there is no bubble.
  - Without an accept: state=IDLE, so=IDLE_LEVEL, so_valid=0, busy=0.
- load_valid while load_ready=0 is ignored. The source must hold the word until accepted. No data corruption; the in-flight frame is unaffected.
- msb_first and load_data changes after accept have no effect on the current frame.
- Reset mid-frame: the frame is aborted immediately and asynchronously. No done pulse. All outputs go to reset values.
- Counter width is $clog2(WIDTH+1). No wrap-around is possible within a frame.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the last data bit, one extra PARITY cycle drives even parity on so (XOR of the latched WIDTH bits, computed at accept).
  - so_valid is high for WIDTH+1 cycles.
  - done and the back-to-back load_ready window move to the PARITY cycle.
  - No load_ready on the last data bit.
- Undefined: the PARITY state and parity register are absent; behaviour is as above.

Decomposition:
- Shared package piso_pkg holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2);
  - the default WIDTH constant;
  - a counter-width function.
- No sub-module is natural: the FSM, counter and shift register are tightly coupled. Implement as a single module.

Test Plan:
- WIDTH=8, load 0x96 with msb_first=0 → so over 8 cycles = 0,1,1,0,1,0,0,1; so_valid high 8 cycles; done on the 8th; then IDLE with so=IDLE_LEVEL.
- Load 0x96 with msb_first=1 → so = 1,0,0,1,0,1,1,0; busy deasserts the cycle after done.
- Load 0x96 (LSB-first), then hold load_valid with 0x3C (MSB-first) → 16 contiguous so_valid cycles: 0,1,1,0,1,0,0,1, then 0,0,1,1,1,1,0,0. The second accept coincides with the first done.
- Pulse load_valid with 0xFF during bits 2..5 of an active frame → ignored; the frame completes unchanged; load_ready stays low until the last bit.
- Assert rst asynchronously at bit 3 of a frame → so_valid/busy drop without a clock edge, no done pulse; the next load of 0x01 (LSB-first) yields 1,0,0,0,0,0,0,0.
- PISO_PARITY_EN defined: 0x96 → 9 valid bits, last = 0; 0x97 → last bit = 1; done on the 9th cycle.
